unstriping: RTL

Receive-side byte un-striping for the four-lane PHY path: the inverse of the transmit striper. Accepts one byte per lane (RL0..RL3) as a single symbol set and re-serializes it into one byte stream toward the demux, in lane order 0,1,2,3. A 2-entry set buffer absorbs arrival jitter. Packet framing is tracked from the STP/END symbols.

---
 rtl/unstriping.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/unstriping.sv
// Four-lane receive un-striper: buffers whole symbol sets and re-serializes them lane 0..3 with STP/END framing.
// Optional build macro UNSTRIPING_SKP_DROP_EN suppresses SKP (8'h1C) bytes in their output slot.
module unstriping (
  input  logic       clk,
  input  logic       reset,
  input  logic       validIn,
  input  logic [7:0] RL0,
  input  logic [7:0] RL1,
  input  logic [7:0] RL2,
  input  logic [7:0] RL3,
  output logic       ready,
  output logic [7:0] toDemux,
  output logic       validOut,
  output logic       inPacket,
  output logic       overflow
);

  localparam logic [7:0] IDLE_SYM = 8'h7C;
  localparam logic [7:0] STP_SYM  = 8'hFB;
  localparam logic [7:0] END_SYM  = 8'hFD;
  localparam logic [7:0] SKP_SYM  = 8'h1C;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LANE1 = 2'd1,
    S_LANE2 = 2'd2,
    S_LANE3 = 2'd3
  } state_t;

  logic [31:0] set_buf_r [2];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  count_r;
  logic [31:0] shift_r;
  logic        pkt_r;
  state_t      state_r;
  state_t      state_nxt_s;

  logic        push_s;
  logic        pop_s;
  logic [7:0]  lane_byte_s;
  logic        slot_valid_s;
  logic        is_skp_s;
  logic        emit_valid_s;
  logic [7:0]  emit_byte_s;
  logic        emit_pkt_s;
  logic        pkt_nxt_s;

  // ready looks only at occupancy, so a full buffer refuses even when a pop happens on the same edge
  assign ready  = !reset && (count_r < 2'd2);
  assign push_s = validIn && ready;

  // Set buffer storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      set_buf_r[0] <= 32'h0000_0000;
      set_buf_r[1] <= 32'h0000_0000;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      count_r      <= 2'd0;
    end else begin
      if (push_s) begin
        set_buf_r[wr_ptr_r] <= {RL3, RL2, RL1, RL0};
        wr_ptr_r            <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Serializer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Serializer next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (count_r != 2'd0) begin
          state_nxt_s = S_LANE1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LANE1: state_nxt_s = S_LANE2;
      S_LANE2: state_nxt_s = S_LANE3;
      S_LANE3: state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Serializer slot outputs: lane 0 comes straight from the buffer head, lanes 1..3 from the shift register
  always_comb begin
    pop_s        = 1'b0;
    lane_byte_s  = IDLE_SYM;
    slot_valid_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (count_r != 2'd0) begin
          pop_s        = 1'b1;
          lane_byte_s  = set_buf_r[rd_ptr_r][7:0];
          slot_valid_s = 1'b1;
        end else begin
          pop_s        = 1'b0;
          lane_byte_s  = IDLE_SYM;
          slot_valid_s = 1'b0;
        end
      end
      S_LANE1: begin
        lane_byte_s  = shift_r[15:8];
        slot_valid_s = 1'b1;
      end
      S_LANE2: begin
        lane_byte_s  = shift_r[23:16];
        slot_valid_s = 1'b1;
      end
      S_LANE3: begin
        lane_byte_s  = shift_r[31:24];
        slot_valid_s = 1'b1;
      end
      default: begin
        pop_s        = 1'b0;
        lane_byte_s  = IDLE_SYM;
        slot_valid_s = 1'b0;
      end
    endcase
  end

  // Shift register holds the set being emitted
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= 32'h0000_0000;
    end else if (pop_s) begin
      shift_r <= set_buf_r[rd_ptr_r];
    end else begin
      shift_r <= shift_r;
    end
  end

  // SKP suppression keeps the slot but blanks it, so it also never touches framing
  always_comb begin
`ifdef UNSTRIPING_SKP_DROP_EN
    is_skp_s = (lane_byte_s == SKP_SYM);
`else
    is_skp_s = 1'b0;
`endif
    emit_valid_s = slot_valid_s && !is_skp_s;
    if (emit_valid_s) begin
      emit_byte_s = lane_byte_s;
    end else begin
      emit_byte_s = IDLE_SYM;
    end
  end

  // Framing: STP itself is outside the packet, END itself is inside
  always_comb begin
    pkt_nxt_s  = pkt_r;
    emit_pkt_s = 1'b0;
    if (emit_valid_s) begin
      if (pkt_r) begin
        emit_pkt_s = 1'b1;
        if (emit_byte_s == END_SYM) begin
          pkt_nxt_s = 1'b0;
        end else begin
          pkt_nxt_s = 1'b1;
        end
      end else begin
        emit_pkt_s = 1'b0;
        if (emit_byte_s == STP_SYM) begin
          pkt_nxt_s = 1'b1;
        end else begin
          pkt_nxt_s = 1'b0;
        end
      end
    end else begin
      emit_pkt_s = 1'b0;
      pkt_nxt_s  = pkt_r;
    end
  end

  // Registered outputs, packet state and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      toDemux  <= IDLE_SYM;
      validOut <= 1'b0;
      inPacket <= 1'b0;
      pkt_r    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      toDemux  <= emit_byte_s;
      validOut <= emit_valid_s;
      inPacket <= emit_pkt_s;
      pkt_r    <= pkt_nxt_s;
      overflow <= overflow | (validIn && !ready);
    end
  end

endmodule
